capture_controller: RTL and testbench
=====================================

Name: capture_controller

Overview:
- Sequences one still capture through the pixel-domain camera pipeline, sitting between the zoom crop output and the JPEG encoder.
- On a start request it waits for a clean frame boundary and passes exactly one frame's line/frame valids to the encoder. It then tracks encoder byte writes until the encoder reports completion, and publishes the byte count and status for the SPI register block.
- Guards against partial frames, buffer overflow and a hung encoder.

Parameters:
- BUFFER_BYTES, 40000, image buffer capacity in bytes; the byte counter saturates here.
- EXPECTED_LINES, 200, lines per captured frame; a mismatch sets short_frame_out.
- TIMEOUT_CYCLES, 2097152, maximum cycles allowed in ENCODE before the error state.

Ports:
- clock_in, input, 1, pixel clock (36MHz).
- reset_n_in, input, 1, reset.
- start_capture_in, input, 1, level from the synchronised SPI register; the rising edge requests a capture.
- abort_in, input, 1, synchronous abort, level.
- frame_valid_in, input, 1, frame valid from the crop stage.
- line_valid_in, input, 1, line valid from the crop stage.
- frame_valid_out, input→encoder, 1, gated frame valid (output).
- line_valid_out, output, 1, gated line valid.
- encoder_start_out, output, 1, one-cycle start pulse to the encoder.
- encoder_write_in, input, 1, encoder wrote one byte to the image buffer this cycle.
- encoder_done_in, input, 1, encoder finished the image (pulse).
- bytes_available_out, output, 16, final image size; 0 until DONE.
- busy_out, output, 1, high in ARM/CAPTURE/ENCODE.
- done_out, output, 1, high in DONE.
- overflow_out, output, 1, sticky; a write was attempted at a full buffer.
- short_frame_out, output, 1, sticky; the captured line count differed from EXPECTED_LINES.
- timeout_out, output, 1, sticky; the encoder did not finish in time.
- state_out, output, 3, debug state: IDLE=0, ARM=1, CAPTURE=2, ENCODE=3, DONE=4, ERROR=5.

Behaviour:
- Interface: single clock clock_in; reset_n_in is asynchronous, active-low.
- Reset values: state IDLE; all outputs 0; internal start_prev=0.
- Start edge: start_edge = start_capture_in & ~start_prev, with start_prev registered each cycle.
- Gating: frame_valid_out = frame_valid_in & gate, and line_valid_out = line_valid_in & gate. Both are combinational with zero latency, so data needs no delay. gate = (state==CAPTURE).
- IDLE / DONE / ERROR + start_edge → ARM:
  - clear the byte counter, line counter, bytes_available_out and all sticky flags;
  - reset timeout counter to 0.
- Start edge in ARM/CAPTURE/ENCODE: ignored.
- ARM:
  - frame_valid_in==0 → CAPTURE next cycle; this guarantees the first gated frame starts from its rising edge.
  - If frame_valid_in stays high, remain in ARM.
- CAPTURE:
  - encoder_start_out=1 on the first cycle only.
  - seen_fv is set when frame_valid_in==1.
  - The line counter increments on each line_valid_in falling edge while frame_valid_in==1 (previous line_valid registered). It saturates at 2^12-1.
  - seen_fv && frame_valid_in==0 → ENCODE. On that transition, short_frame_out <= (lines != EXPECTED_LINES).
  - encoder_done_in is ignored in CAPTURE.
- Byte counting (CAPTURE and ENCODE), per encoder_write_in:
  - count < BUFFER_BYTES → count+1;
  - count == BUFFER_BYTES → hold, set overflow_out.
- ENCODE:
  - The timeout counter increments each cycle.
  - encoder_done_in → DONE, with bytes_available_out <= count (including a write in the same cycle).
  - Otherwise, counter == TIMEOUT_CYCLES-1 → ERROR, timeout_out=1.
  - encoder_done_in in the timeout cycle: done wins.
- DONE: holds done_out=1 and bytes_available_out until the next start_edge.
- ERROR: done_out=0, bytes_available_out=0; the flags hold.
- abort_in=1 in any state → IDLE next cycle:
  - gate drops on the following cycle, so downstream sees frame_valid fall mid-frame;
  - counters are cleared; flags are cleared.
  - abort_in has priority over start_edge and encoder_done_in in the same cycle.
- Widths: byte counter 16-bit; timeout counter sized to clog2(TIMEOUT_CYCLES).
- Asynchronous reset mid-operation returns to IDLE immediately, with gate low.

Test Plan (bench params: EXPECTED_LINES=12, BUFFER_BYTES=16, TIMEOUT_CYCLES=64):
- Nominal: frame_valid low and start rises → ARM 1 cycle, then CAPTURE with encoder_start_out pulse. A 12-line frame passes gated. Encoder writes 10 bytes, then done → DONE, bytes_available_out=10, short_frame_out=0.
- Mid-frame start: start asserted while frame_valid high → stays in ARM until frame_valid falls; the partial frame never appears on frame_valid_out; the next full frame is gated.
- Overflow: 20 encoder writes then done → bytes_available_out=16, overflow_out=1.
- Timeout and short frame: 10-line frame, no encoder_done → ERROR after 64 ENCODE cycles, timeout_out=1, short_frame_out=1, done_out=0. A new start clears all flags.
- Abort: abort mid-CAPTURE → state_out=0 next cycle, frame_valid_out low from the following cycle. A simultaneous abort and encoder_done in ENCODE → IDLE, bytes_available_out=0.
- Ignored start: a second start edge during ENCODE → no restart, no extra encoder_start_out pulse, count unchanged.

Source files
------------

// File: rtl/capture_controller.sv
`timescale 1ns/1ps
// Still-capture sequencer between the zoom crop output and the JPEG encoder.
// Gates exactly one clean frame, counts encoder bytes and reports size/status.
module capture_controller #(
  parameter int BUFFER_BYTES   = 40000,
  parameter int EXPECTED_LINES = 200,
  parameter int TIMEOUT_CYCLES = 2097152
) (
  input  logic        clock_in,
  input  logic        reset_n_in,
  input  logic        start_capture_in,
  input  logic        abort_in,
  input  logic        frame_valid_in,
  input  logic        line_valid_in,
  output logic        frame_valid_out,
  output logic        line_valid_out,
  output logic        encoder_start_out,
  input  logic        encoder_write_in,
  input  logic        encoder_done_in,
  output logic [15:0] bytes_available_out,
  output logic        busy_out,
  output logic        done_out,
  output logic        overflow_out,
  output logic        short_frame_out,
  output logic        timeout_out,
  output logic [2:0]  state_out
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [15:0]   BUF_MAX   = 16'(BUFFER_BYTES);
  localparam logic [11:0]   LINES_EXP = 12'(EXPECTED_LINES);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    CAPTURE = 3'd2,
    ENCODE  = 3'd3,
    DONE    = 3'd4,
    ERROR   = 3'd5
  } state_t;

  state_t        state;
  logic          start_prev;
  logic          lv_prev;
  logic          seen_fv;
  logic [15:0]   byte_count;
  logic [11:0]   line_count;
  logic [TW-1:0] timeout_count;

  logic          start_edge;
  logic          gate;
  logic          counting;
  logic          lv_fall;
  logic [15:0]   byte_count_next;

  assign start_edge = start_capture_in & ~start_prev;
  assign gate       = (state == CAPTURE);
  assign counting   = (state == CAPTURE) || (state == ENCODE);
  assign lv_fall    = lv_prev & ~line_valid_in & frame_valid_in;

  // Next byte count includes a write landing in the same cycle as encoder done.
  assign byte_count_next = (counting && encoder_write_in && (byte_count != BUF_MAX))
                           ? byte_count + 16'd1 : byte_count;

  assign frame_valid_out = frame_valid_in & gate;
  assign line_valid_out  = line_valid_in & gate;
  assign state_out       = state;
  assign busy_out        = (state == ARM) || (state == CAPTURE) || (state == ENCODE);
  assign done_out        = (state == DONE);

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state               <= IDLE;
      start_prev          <= 1'b0;
      lv_prev             <= 1'b0;
      seen_fv             <= 1'b0;
      byte_count          <= '0;
      line_count          <= '0;
      timeout_count       <= '0;
      encoder_start_out   <= 1'b0;
      bytes_available_out <= '0;
      overflow_out        <= 1'b0;
      short_frame_out     <= 1'b0;
      timeout_out         <= 1'b0;
    end else begin
      start_prev        <= start_capture_in;
      lv_prev           <= line_valid_in;
      encoder_start_out <= 1'b0;
      if (abort_in) begin
        state               <= IDLE;
        seen_fv             <= 1'b0;
        byte_count          <= '0;
        line_count          <= '0;
        timeout_count       <= '0;
        bytes_available_out <= '0;
        overflow_out        <= 1'b0;
        short_frame_out     <= 1'b0;
        timeout_out         <= 1'b0;
      end else begin
        byte_count <= byte_count_next;
        if (counting && encoder_write_in && (byte_count == BUF_MAX))
          overflow_out <= 1'b1;
        case (state)
          IDLE, DONE, ERROR: begin
            if (start_edge) begin
              state               <= ARM;
              byte_count          <= '0;
              line_count          <= '0;
              timeout_count       <= '0;
              bytes_available_out <= '0;
              overflow_out        <= 1'b0;
              short_frame_out     <= 1'b0;
              timeout_out         <= 1'b0;
            end
          end
          // Waiting for frame valid low so the gated frame begins at its rising edge.
          ARM: begin
            if (!frame_valid_in) begin
              state             <= CAPTURE;
              encoder_start_out <= 1'b1;
              seen_fv           <= 1'b0;
              line_count        <= '0;
            end
          end
          CAPTURE: begin
            if (frame_valid_in)
              seen_fv <= 1'b1;
            if (lv_fall && (line_count != 12'hFFF))
              line_count <= line_count + 12'd1;
            if (seen_fv && !frame_valid_in) begin
              state           <= ENCODE;
              short_frame_out <= (line_count != LINES_EXP);
            end
          end
          ENCODE: begin
            timeout_count <= timeout_count + 1'b1;
            if (encoder_done_in) begin
              state               <= DONE;
              bytes_available_out <= byte_count_next;
            end else if (timeout_count == TO_LAST) begin
              state       <= ERROR;
              timeout_out <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_controller.sv
`timescale 1ns/1ps
// Randomised self-checking bench for capture_controller with small parameters.
// Expectations come from frame/write counts the bench itself generates.
module tb_capture_controller;

  localparam int EXP_LINES = 12;
  localparam int BUF       = 16;
  localparam int TO        = 64;

  logic        clock_in = 1'b0;
  logic        reset_n_in = 1'b0;
  logic        start_capture_in = 1'b0;
  logic        abort_in = 1'b0;
  logic        frame_valid_in = 1'b0;
  logic        line_valid_in = 1'b0;
  logic        encoder_write_in = 1'b0;
  logic        encoder_done_in = 1'b0;
  logic        frame_valid_out;
  logic        line_valid_out;
  logic        encoder_start_out;
  logic [15:0] bytes_available_out;
  logic        busy_out;
  logic        done_out;
  logic        overflow_out;
  logic        short_frame_out;
  logic        timeout_out;
  logic [2:0]  state_out;

  int tests_run    = 0;
  int tests_failed = 0;
  int gate_errs    = 0;
  int start_pulses = 0;
  bit gate_expect  = 1'b0;

  capture_controller #(
    .BUFFER_BYTES  (BUF),
    .EXPECTED_LINES(EXP_LINES),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock_in           (clock_in),
    .reset_n_in         (reset_n_in),
    .start_capture_in   (start_capture_in),
    .abort_in           (abort_in),
    .frame_valid_in     (frame_valid_in),
    .line_valid_in      (line_valid_in),
    .frame_valid_out    (frame_valid_out),
    .line_valid_out     (line_valid_out),
    .encoder_start_out  (encoder_start_out),
    .encoder_write_in   (encoder_write_in),
    .encoder_done_in    (encoder_done_in),
    .bytes_available_out(bytes_available_out),
    .busy_out           (busy_out),
    .done_out           (done_out),
    .overflow_out       (overflow_out),
    .short_frame_out    (short_frame_out),
    .timeout_out        (timeout_out),
    .state_out          (state_out)
  );

  always #5 clock_in = ~clock_in;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // One clock cycle: inputs applied 1ns after the edge, outputs observed 2ns later.
  task automatic drive(input bit fv, input bit lv, input bit wr, input bit dn);
    frame_valid_in   = fv;
    line_valid_in    = lv;
    encoder_write_in = wr;
    encoder_done_in  = dn;
    #2;
    if (frame_valid_out !== (fv & gate_expect) || line_valid_out !== (lv & gate_expect))
      gate_errs++;
    if (encoder_start_out === 1'b1)
      start_pulses++;
    @(posedge clock_in);
    #1;
  endtask

  task automatic request_start(input bit fv);
    start_capture_in = 1'b1;
    drive(fv, 1'b0, 1'b0, 1'b0);
    start_capture_in = 1'b0;
  endtask

  task automatic begin_capture();
    gate_expect  = 1'b0;
    gate_errs    = 0;
    start_pulses = 0;
    request_start(1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    gate_expect = 1'b1;
  endtask

  task automatic send_frame(input int lines, input int llen, input int gap);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int l = 0; l < lines; l++) begin
      for (int c = 0; c < llen; c++) drive(1'b1, 1'b1, 1'b0, 1'b0);
      for (int c = 0; c < gap; c++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic encode_writes(input int writes, input bit done_with_write);
    int plain;
    plain = done_with_write ? writes - 1 : writes;
    for (int i = 0; i < plain; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      if ($urandom_range(0, 1) == 1) drive(1'b0, 1'b0, 1'b0, 1'b0);
    end
    if (done_with_write) drive(1'b0, 1'b0, 1'b1, 1'b1);
    else                 drive(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    reset_n_in     = 1'b0;
    frame_valid_in = 1'b1;
    line_valid_in  = 1'b1;
    repeat (3) @(posedge clock_in);
    #1;
    tests_run++;
    if (state_out !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got %0d expected 0", state_out);
    end
    tests_run++;
    if ({busy_out, done_out, overflow_out, short_frame_out, timeout_out, encoder_start_out,
         frame_valid_out, line_valid_out, bytes_available_out} !== 24'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: busy=%b done=%b ovf=%b short=%b to=%b start=%b fv=%b lv=%b bytes=%0d expected all 0",
               busy_out, done_out, overflow_out, short_frame_out, timeout_out, encoder_start_out,
               frame_valid_out, line_valid_out, bytes_available_out);
    end
    frame_valid_in = 1'b0;
    line_valid_in  = 1'b0;
    reset_n_in     = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_nominal();
    int llen, gap, writes;
    bit dww;
    for (int it = 0; it < 3; it++) begin
      llen   = $urandom_range(1, 4);
      gap    = $urandom_range(1, 3);
      writes = $urandom_range(1, BUF - 1);
      dww    = 1'($urandom_range(0, 1));
      gate_expect  = 1'b0;
      gate_errs    = 0;
      start_pulses = 0;
      request_start(1'b0);
      tests_run++;
      if (state_out !== 3'd1 || busy_out !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL nominal_arm: state=%0d busy=%b expected 1/1", state_out, busy_out);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (state_out !== 3'd2 || encoder_start_out !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL nominal_capture_start: state=%0d start=%b expected 2/1", state_out, encoder_start_out);
      end
      gate_expect = 1'b1;
      send_frame(EXP_LINES, llen, gap);
      gate_expect = 1'b0;
      tests_run++;
      if (state_out !== 3'd3 || short_frame_out !== 1'b0 || bytes_available_out !== 16'd0) begin
        tests_failed++;
        $display("[TB] FAIL nominal_encode: state=%0d short=%b bytes=%0d expected 3/0/0",
                 state_out, short_frame_out, bytes_available_out);
      end
      encode_writes(writes, dww);
      tests_run++;
      if (state_out !== 3'd4 || done_out !== 1'b1 || busy_out !== 1'b0 ||
          bytes_available_out !== 16'(writes) || overflow_out !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL nominal_done: state=%0d done=%b busy=%b bytes=%0d ovf=%b expected 4/1/0/%0d/0",
                 state_out, done_out, busy_out, bytes_available_out, overflow_out, writes);
      end
      tests_run++;
      if (gate_errs !== 0 || start_pulses !== 1) begin
        tests_failed++;
        $display("[TB] FAIL nominal_gating: gate_errs=%0d pulses=%0d expected 0/1", gate_errs, start_pulses);
      end
      repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (done_out !== 1'b1 || bytes_available_out !== 16'(writes)) begin
        tests_failed++;
        $display("[TB] FAIL nominal_hold: done=%b bytes=%0d expected 1/%0d", done_out, bytes_available_out, writes);
      end
    end
  endtask

  task automatic test_mid_frame_start();
    int partial, writes;
    partial      = $urandom_range(2, 5);
    writes       = $urandom_range(1, 10);
    gate_expect  = 1'b0;
    gate_errs    = 0;
    start_pulses = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    request_start(1'b1);
    for (int l = 0; l < partial; l++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
    end
    tests_run++;
    if (state_out !== 3'd1 || frame_valid_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midframe_hold_arm: state=%0d fv_out=%b expected 1/0", state_out, frame_valid_out);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    gate_expect = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(EXP_LINES, $urandom_range(1, 3), $urandom_range(1, 2));
    gate_expect = 1'b0;
    tests_run++;
    if (state_out !== 3'd3 || short_frame_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midframe_encode: state=%0d short=%b expected 3/0", state_out, short_frame_out);
    end
    encode_writes(writes, 1'b0);
    tests_run++;
    if (gate_errs !== 0 || start_pulses !== 1 || bytes_available_out !== 16'(writes)) begin
      tests_failed++;
      $display("[TB] FAIL midframe_gating: gate_errs=%0d pulses=%0d bytes=%0d expected 0/1/%0d",
               gate_errs, start_pulses, bytes_available_out, writes);
    end
  endtask

  task automatic test_overflow();
    int writes;
    writes = $urandom_range(BUF + 1, BUF + 8);
    begin_capture();
    send_frame(EXP_LINES, 2, 1);
    gate_expect = 1'b0;
    encode_writes(writes, 1'($urandom_range(0, 1)));
    tests_run++;
    if (state_out !== 3'd4 || bytes_available_out !== 16'(BUF) || overflow_out !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL overflow: state=%0d bytes=%0d ovf=%b expected 4/%0d/1 (writes=%0d)",
               state_out, bytes_available_out, overflow_out, BUF, writes);
    end
  endtask

  task automatic test_timeout_short();
    int lines, n;
    lines = ($urandom_range(0, 1) == 0) ? $urandom_range(5, EXP_LINES - 1) : $urandom_range(EXP_LINES + 1, 16);
    begin_capture();
    send_frame(lines, 1, 1);
    gate_expect = 1'b0;
    tests_run++;
    if (state_out !== 3'd3 || short_frame_out !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL short_frame: state=%0d short=%b expected 3/1 (lines=%0d)", state_out, short_frame_out, lines);
    end
    n = 0;
    while (state_out !== 3'd5 && n < 200) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    tests_run++;
    if (n !== TO) begin
      tests_failed++;
      $display("[TB] FAIL timeout_cycles: got %0d encode cycles expected %0d", n, TO);
    end
    tests_run++;
    if (timeout_out !== 1'b1 || short_frame_out !== 1'b1 || done_out !== 1'b0 ||
        busy_out !== 1'b0 || bytes_available_out !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_flags: to=%b short=%b done=%b busy=%b bytes=%0d expected 1/1/0/0/0",
               timeout_out, short_frame_out, done_out, busy_out, bytes_available_out);
    end
    request_start(1'b0);
    tests_run++;
    if (state_out !== 3'd1 || {timeout_out, short_frame_out, overflow_out} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL restart_clears: state=%0d flags=%b expected 1/000",
               state_out, {timeout_out, short_frame_out, overflow_out});
    end
    abort_in = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    abort_in = 1'b0;
  endtask

  task automatic test_abort();
    int k;
    begin_capture();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int l = 0; l < 3; l++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
    end
    abort_in = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    abort_in = 1'b0;
    tests_run++;
    if (state_out !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL abort_state: got %0d expected 0", state_out);
    end
    gate_expect = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (frame_valid_out !== 1'b0 || gate_errs !== 0) begin
      tests_failed++;
      $display("[TB] FAIL abort_gate: fv_out=%b gate_errs=%0d expected 0/0", frame_valid_out, gate_errs);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (state_out !== 3'd0 || busy_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_stays_idle: state=%0d busy=%b expected 0/0", state_out, busy_out);
    end
    // Abort coinciding with encoder done must win.
    k = $urandom_range(1, 8);
    begin_capture();
    send_frame(EXP_LINES, 1, 1);
    gate_expect = 1'b0;
    for (int i = 0; i < k; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    abort_in = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    abort_in = 1'b0;
    tests_run++;
    if (state_out !== 3'd0 || bytes_available_out !== 16'd0 || done_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_vs_done: state=%0d bytes=%0d done=%b expected 0/0/0",
               state_out, bytes_available_out, done_out);
    end
  endtask

  task automatic test_ignored_start();
    int k1, k2;
    k1 = $urandom_range(1, 5);
    k2 = $urandom_range(1, 8);
    begin_capture();
    send_frame(EXP_LINES, 2, 2);
    gate_expect = 1'b0;
    for (int i = 0; i < k1; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    request_start(1'b0);
    tests_run++;
    if (state_out !== 3'd3 || encoder_start_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ignored_start_state: state=%0d start=%b expected 3/0", state_out, encoder_start_out);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    encode_writes(k2, 1'($urandom_range(0, 1)));
    tests_run++;
    if (state_out !== 3'd4 || bytes_available_out !== 16'(k1 + k2) || start_pulses !== 1) begin
      tests_failed++;
      $display("[TB] FAIL ignored_start_count: state=%0d bytes=%0d pulses=%0d expected 4/%0d/1",
               state_out, bytes_available_out, start_pulses, k1 + k2);
    end
  endtask

  task automatic test_async_reset();
    begin_capture();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    frame_valid_in = 1'b1;
    line_valid_in  = 1'b1;
    #2;
    reset_n_in = 1'b0;
    #1;
    tests_run++;
    if (state_out !== 3'd0 || frame_valid_out !== 1'b0 || line_valid_out !== 1'b0 || busy_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: state=%0d fv=%b lv=%b busy=%b expected 0/0/0/0",
               state_out, frame_valid_out, line_valid_out, busy_out);
    end
    @(posedge clock_in);
    #1;
    reset_n_in  = 1'b1;
    gate_expect = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_mid_frame_start();
    test_overflow();
    test_timeout_short();
    test_abort();
    test_ignored_start();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
